// File: rtl/commit_trace_buffer.sv
// -----------------------------------------------------------------------------
// commit_trace_buffer
//
// Purpose:
//   Sits behind the single-cycle core and records its retire stream. Each
//   retire event (update_i && enable_i) takes the next sequence number and is
//   written into a FIFO. Records drain to a trace sink over a valid/ready
//   handshake. If an event arrives while the FIFO is full and nothing is being
//   popped, the event is dropped: its sequence number is still used up, so the
//   sink sees a gap in tr_seq_o. A sticky overflow flag and a saturating drop
//   counter report the losses.
//
// Ports:
//   clk_i, rst_i        clock; synchronous active-high reset
//   enable_i            capture enable (0: update_i ignored, no seq use)
//   update_i            core retired an instruction this cycle
//   pc_i, instr_i       retired pc and instruction word
//   reg_addr_i/data_i   destination register (0 = none) and its write data
//   mem_addr_i/data_i   store address and store data
//   tr_valid_o/ready_i  head-record handshake towards the trace sink
//   tr_seq_o .. tr_mem_data_o   head record fields (all 0 when empty)
//   count_o             current FIFO occupancy, 0..DEPTH
//   overflow_o          sticky, set on the first dropped event
//   drop_cnt_o          number of dropped events, saturating
// -----------------------------------------------------------------------------
module commit_trace_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int SEQW  = 16,
  parameter int CNTW  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic                     update_i,
  input  logic [XLEN-1:0]          pc_i,
  input  logic [XLEN-1:0]          instr_i,
  input  logic [4:0]               reg_addr_i,
  input  logic [XLEN-1:0]          reg_data_i,
  input  logic [XLEN-1:0]          mem_addr_i,
  input  logic [XLEN-1:0]          mem_data_i,
  output logic                     tr_valid_o,
  input  logic                     tr_ready_i,
  output logic [SEQW-1:0]          tr_seq_o,
  output logic [XLEN-1:0]          tr_pc_o,
  output logic [XLEN-1:0]          tr_instr_o,
  output logic [4:0]               tr_rd_o,
  output logic [XLEN-1:0]          tr_rd_data_o,
  output logic [XLEN-1:0]          tr_mem_addr_o,
  output logic [XLEN-1:0]          tr_mem_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic [CNTW-1:0]          drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  // Record storage, one array per field. Not reset: entries are only
  // observable through the head pointer while count_q is nonzero.
  logic [SEQW-1:0] seq_mem      [DEPTH];
  logic [XLEN-1:0] pc_mem       [DEPTH];
  logic [XLEN-1:0] instr_mem    [DEPTH];
  logic [4:0]      rd_mem       [DEPTH];
  logic [XLEN-1:0] rd_data_mem  [DEPTH];
  logic [XLEN-1:0] mem_addr_mem [DEPTH];
  logic [XLEN-1:0] mem_data_mem [DEPTH];

  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW:0]     count_q;
  logic [SEQW-1:0] seq_q;
  logic            overflow_q;
  logic [CNTW-1:0] drop_cnt_q;

  logic            event_w;
  logic            fifo_empty;
  logic            fifo_full;
  logic            pop_w;
  logic            push_w;
  logic            drop_w;
  logic [XLEN-1:0] rd_data_w;

  assign event_w    = update_i & enable_i;
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_COUNT);
  assign pop_w      = ~fifo_empty & tr_ready_i;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_w     = event_w & (~fifo_full | pop_w);
  assign drop_w     = event_w & fifo_full & ~pop_w;
  assign rd_data_w  = (reg_addr_i == 5'd0) ? '0 : reg_data_i;

  // Pointers, occupancy, sequence counter and drop bookkeeping. Pointers wrap
  // naturally because DEPTH is a power of two. The sequence number advances
  // on every event, dropped or not, which is what makes drops visible as gaps.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      if (push_w) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_w) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push_w && !pop_w) begin
        count_q <= count_q + 1'b1;
      end else if (pop_w && !push_w) begin
        count_q <= count_q - 1'b1;
      end
      if (event_w) begin
        seq_q <= seq_q + 1'b1;
      end
      if (drop_w) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != '1) begin
          drop_cnt_q <= drop_cnt_q + 1'b1;
        end
      end
    end
  end

  // Tail write of the packed record.
  always_ff @(posedge clk_i) begin
    if (push_w && !rst_i) begin
      seq_mem[wr_ptr_q]      <= seq_q;
      pc_mem[wr_ptr_q]       <= pc_i;
      instr_mem[wr_ptr_q]    <= instr_i;
      rd_mem[wr_ptr_q]       <= reg_addr_i;
      rd_data_mem[wr_ptr_q]  <= rd_data_w;
      mem_addr_mem[wr_ptr_q] <= mem_addr_i;
      mem_data_mem[wr_ptr_q] <= mem_data_i;
    end
  end

  // Head record comes straight from storage registers addressed by the
  // registered read pointer, so it only changes at a clock edge and holds
  // while the sink stalls. Fields are forced to 0 when the FIFO is empty so
  // stale entries never leak out.
  assign tr_valid_o    = ~fifo_empty;
  assign tr_seq_o      = fifo_empty ? '0 : seq_mem[rd_ptr_q];
  assign tr_pc_o       = fifo_empty ? '0 : pc_mem[rd_ptr_q];
  assign tr_instr_o    = fifo_empty ? '0 : instr_mem[rd_ptr_q];
  assign tr_rd_o       = fifo_empty ? '0 : rd_mem[rd_ptr_q];
  assign tr_rd_data_o  = fifo_empty ? '0 : rd_data_mem[rd_ptr_q];
  assign tr_mem_addr_o = fifo_empty ? '0 : mem_addr_mem[rd_ptr_q];
  assign tr_mem_data_o = fifo_empty ? '0 : mem_data_mem[rd_ptr_q];

  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// -----------------------------------------------------------------------------
// tb_commit_trace_buffer
//
// Drives two instances of commit_trace_buffer from the same stimulus: one with
// the default 16-bit sequence number and one with a 4-bit sequence number, so
// sequence wrap is exercised continuously. A reference model updates at each
// rising edge and pushes expected records into a scoreboard queue; a monitor
// on the falling edge pops and compares whenever the sink handshake fires.
// -----------------------------------------------------------------------------
module tb_commit_trace_buffer;

  localparam int XLEN   = 32;
  localparam int DEPTH  = 16;
  localparam int SEQW   = 16;
  localparam int SEQW_S = 4;
  localparam int CNTW   = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst  = 1'b1;
  logic            en   = 1'b0;
  logic            upd  = 1'b0;
  logic            rdy  = 1'b0;
  logic [XLEN-1:0] pc   = '0;
  logic [XLEN-1:0] instr = '0;
  logic [4:0]      rd   = '0;
  logic [XLEN-1:0] rdata = '0;
  logic [XLEN-1:0] maddr = '0;
  logic [XLEN-1:0] mdata = '0;

  logic              valid_a, ovf_a;
  logic [SEQW-1:0]   seq_a;
  logic [XLEN-1:0]   pc_a, instr_a, rd_data_a, maddr_a, mdata_a;
  logic [4:0]        rd_a;
  logic [4:0]        count_a;
  logic [CNTW-1:0]   drop_a;

  logic              valid_b, ovf_b;
  logic [SEQW_S-1:0] seq_b;
  logic [XLEN-1:0]   pc_b, instr_b, rd_data_b, maddr_b, mdata_b;
  logic [4:0]        rd_b;
  logic [4:0]        count_b;
  logic [CNTW-1:0]   drop_b;

  commit_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .SEQW(SEQW), .CNTW(CNTW)) dut_a (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .update_i(upd),
    .pc_i(pc), .instr_i(instr), .reg_addr_i(rd), .reg_data_i(rdata),
    .mem_addr_i(maddr), .mem_data_i(mdata),
    .tr_valid_o(valid_a), .tr_ready_i(rdy), .tr_seq_o(seq_a),
    .tr_pc_o(pc_a), .tr_instr_o(instr_a), .tr_rd_o(rd_a),
    .tr_rd_data_o(rd_data_a), .tr_mem_addr_o(maddr_a), .tr_mem_data_o(mdata_a),
    .count_o(count_a), .overflow_o(ovf_a), .drop_cnt_o(drop_a)
  );

  commit_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .SEQW(SEQW_S), .CNTW(CNTW)) dut_b (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .update_i(upd),
    .pc_i(pc), .instr_i(instr), .reg_addr_i(rd), .reg_data_i(rdata),
    .mem_addr_i(maddr), .mem_data_i(mdata),
    .tr_valid_o(valid_b), .tr_ready_i(rdy), .tr_seq_o(seq_b),
    .tr_pc_o(pc_b), .tr_instr_o(instr_b), .tr_rd_o(rd_b),
    .tr_rd_data_o(rd_data_b), .tr_mem_addr_o(maddr_b), .tr_mem_data_o(mdata_b),
    .count_o(count_b), .overflow_o(ovf_b), .drop_cnt_o(drop_b)
  );

  typedef struct {
    logic [31:0]     seq;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd_data;
    logic [XLEN-1:0] maddr;
    logic [XLEN-1:0] mdata;
  } rec_t;

  rec_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state: occupancy, unbounded sequence number, drop info.
  int   mcount = 0;
  int   mseq   = 0;
  int   mdrop  = 0;
  bit   movf   = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: the FIFO is an abstract queue of records with a bound
  // of DEPTH; every event takes a sequence number, and is kept if there is
  // room or the head leaves this same cycle.
  always @(posedge clk) begin : model
    bit   mpop;
    rec_t r;
    if (rst) begin
      sb.delete();
      mcount = 0;
      mseq   = 0;
      mdrop  = 0;
      movf   = 1'b0;
    end else begin
      mpop = (mcount > 0) && rdy;
      if (upd && en) begin
        if (mcount < DEPTH || mpop) begin
          r.seq     = mseq;
          r.pc      = pc;
          r.instr   = instr;
          r.rd      = rd;
          r.rd_data = (rd == 5'd0) ? '0 : rdata;
          r.maddr   = maddr;
          r.mdata   = mdata;
          sb.push_back(r);
          mcount++;
        end else begin
          movf = 1'b1;
          if (mdrop < (1 << CNTW) - 1) mdrop++;
        end
        mseq++;
      end
      if (mpop) mcount--;
    end
  end

  // Monitor: status checks every cycle, record checks on each handshake, and
  // stability of the head record across a stalled cycle.
  bit   hold = 1'b0;
  rec_t held;
  always @(negedge clk) begin : monitor
    rec_t e;
    checkOutput("count", 32'(count_a), 32'(mcount));
    checkOutput("valid", 32'(valid_a), 32'(mcount > 0));
    checkOutput("overflow", 32'(ovf_a), 32'(movf));
    checkOutput("drop_cnt", 32'(drop_a), 32'(mdrop));
    checkOutput("count_s", 32'(count_b), 32'(mcount));
    checkOutput("valid_s", 32'(valid_b), 32'(mcount > 0));
    checkOutput("drop_cnt_s", 32'(drop_b), 32'(mdrop));
    if (hold) begin
      checkOutput("hold_seq", 32'(seq_a), held.seq);
      checkOutput("hold_pc", pc_a, held.pc);
      checkOutput("hold_instr", instr_a, held.instr);
      checkOutput("hold_rd", 32'(rd_a), 32'(held.rd));
      checkOutput("hold_rd_data", rd_data_a, held.rd_data);
      checkOutput("hold_maddr", maddr_a, held.maddr);
      checkOutput("hold_mdata", mdata_a, held.mdata);
    end
    if (valid_a && rdy) begin
      checkOutput("sb_avail", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("seq", 32'(seq_a), 32'(e.seq[SEQW-1:0]));
        checkOutput("seq_s", 32'(seq_b), 32'(e.seq[SEQW_S-1:0]));
        checkOutput("pc", pc_a, e.pc);
        checkOutput("instr", instr_a, e.instr);
        checkOutput("rd", 32'(rd_a), 32'(e.rd));
        checkOutput("rd_data", rd_data_a, e.rd_data);
        checkOutput("maddr", maddr_a, e.maddr);
        checkOutput("mdata", mdata_a, e.mdata);
        checkOutput("pc_s", pc_b, e.pc);
        checkOutput("instr_s", instr_b, e.instr);
        checkOutput("rd_s", 32'(rd_b), 32'(e.rd));
        checkOutput("rd_data_s", rd_data_b, e.rd_data);
        checkOutput("maddr_s", maddr_b, e.maddr);
        checkOutput("mdata_s", mdata_b, e.mdata);
        checkOutput("ovf_s", 32'(ovf_b), 32'(movf));
      end
    end
    hold = valid_a && !rdy && !rst;
    held.seq     = 32'(seq_a);
    held.pc      = pc_a;
    held.instr   = instr_a;
    held.rd      = rd_a;
    held.rd_data = rd_data_a;
    held.maddr   = maddr_a;
    held.mdata   = mdata_a;
  end

  // One cycle of stimulus with random payload; inputs change 1 time unit
  // after the active edge and are consumed by the following edge.
  task automatic applyStimulus(input logic r, input logic e, input logic u, input logic k);
    rst   = r;
    en    = e;
    upd   = u;
    rdy   = k;
    pc    = $urandom;
    instr = $urandom;
    rd    = 5'($urandom_range(0, 31));
    rdata = $urandom;
    maddr = $urandom;
    mdata = $urandom;
    @(posedge clk);
    #1;
  endtask

  task automatic applyDirected(input logic [XLEN-1:0] p, input logic [4:0] d,
                               input logic [XLEN-1:0] v);
    rst   = 1'b0;
    en    = 1'b1;
    upd   = 1'b1;
    rdy   = 1'b1;
    pc    = p;
    instr = 32'h00000013;
    rd    = d;
    rdata = v;
    maddr = '0;
    mdata = '0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset and three directed retires with the sink always ready.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_valid", 32'(valid_a), 32'd0);
    checkOutput("rst_pc", pc_a, 32'd0);
    applyDirected(32'h80000000, 5'd1, 32'h11);
    applyDirected(32'h80000004, 5'd2, 32'h22);
    applyDirected(32'h80000008, 5'd0, 32'h33);
    checkOutput("t1_head_rd_data", rd_data_a, 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("t1_count", 32'(count_a), 32'd0);

    // Overflow: 19 events into a stalled sink, then drain and one more event.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH + 3; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("t2_count", 32'(count_a), 32'd16);
    checkOutput("t2_drop", 32'(drop_a), 32'd3);
    checkOutput("t2_ovf", 32'(ovf_a), 32'd1);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("t2_drained", 32'(count_a), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("t2_next_seq", 32'(seq_a), 32'd19);
    checkOutput("t2_ovf_sticky", 32'(ovf_a), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);

    // Full FIFO with simultaneous push and pop every cycle.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
      checkOutput("t3_count_full", 32'(count_a), 32'd16);
      checkOutput("t3_no_drop", 32'(drop_a), 32'd0);
    end
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);

    // Random events with the sink toggling ready every cycle.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 200; i++)
      applyStimulus(1'b0, 1'b1, ($urandom_range(0, 9) < 4), 1'(i % 2));
    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);

    // Reset with entries queued; reset must beat a concurrent push and pop.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'(i % 2));
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("t5_valid", 32'(valid_a), 32'd0);
    checkOutput("t5_count", 32'(count_a), 32'd0);
    checkOutput("t5_drop", 32'(drop_a), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("t5_seq0", 32'(seq_a), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);

    // Capture disabled: no pushes, no sequence numbers consumed.
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("t6_count", 32'(count_a), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("t6_seq_cont", 32'(seq_a), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);

    // 18 back-to-back events: the 4-bit instance wraps 15 -> 0.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 18; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("t6_seq17", 32'(seq_a), 32'd17);
    checkOutput("t6_seq_wrap", 32'(seq_b), 32'd1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);

    @(negedge clk);
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
